sa48_sequencer: RTL and testbench

SA48_SEQUENCER -- requirements
Module: sa48_sequencer

---
 rtl/sa48_sequencer.sv | 156 +++++++++++++++
 tb/tb_sa48_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sa48_sequencer.sv
// Sequencer for a 48-bit add on an external 12-bit-slice datapath. It latches the
// operands, walks the four slices, then waits for the datapath, captures the result and pulses done.
//
// state | meaning
// IDLE  | waiting for start; operands latched on an accepted start
// S1    | slice 0 (bits 11:0) on bus_a/bus_b, flag=0001
// S2    | slice 1 (bits 23:12), flag=0010
// S3    | slice 2 (bits 35:24), flag=0100
// S4    | slice 3 (bits 47:36), flag=1000; loads the wait counter
// LOAD  | load_ready held for LOAD_WAIT cycles
// CAPT  | dp_sum/dp_co registered into sum/co
// DONE  | one-cycle done pulse, busy low
module sa48_sequencer #(
   parameter int unsigned LOAD_WAIT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [47:0] a_in,
   input  logic [47:0] b_in,
   input  logic        ci_in,
   output logic [11:0] bus_a,
   output logic [11:0] bus_b,
   output logic [3:0]  flag,
   output logic        load_ready,
   output logic        ci48,
   input  logic [47:0] dp_sum,
   input  logic        dp_co,
   output logic        busy,
   output logic        done,
   output logic [47:0] sum,
   output logic        co
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_S1,
      ST_S2,
      ST_S3,
      ST_S4,
      ST_LOAD,
      ST_CAPT,
      ST_DONE
   } state_t;

   localparam logic [2:0] LW_TC = 3'(LOAD_WAIT - 1);

   state_t      r_state;
   state_t      w_next;
   logic [47:0] r_a;
   logic [47:0] r_b;
   logic        r_ci;
   logic [2:0]  r_cnt;
   logic [47:0] r_sum;
   logic        r_co;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a   <= '0;
         r_b   <= '0;
         r_ci  <= 1'b0;
         r_cnt <= '0;
         r_sum <= '0;
         r_co  <= 1'b0;
      end else begin
         if (r_state == ST_IDLE && start) begin
            r_a  <= a_in;
            r_b  <= b_in;
            r_ci <= ci_in;
         end
         // Down-counter: loaded on the way into LOAD, LOAD exits at terminal count 0.
         if (r_state == ST_S4) begin
            r_cnt <= LW_TC;
         end else if (r_state == ST_LOAD && r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
         end
         if (r_state == ST_CAPT) begin
            r_sum <= dp_sum;
            r_co  <= dp_co;
         end
      end
   end

   always_comb begin
      w_next     = r_state;
      flag       = 4'b0000;
      bus_a      = 12'd0;
      bus_b      = 12'd0;
      load_ready = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               w_next = ST_S1;
            end
         end
         ST_S1: begin
            flag   = 4'b0001;
            bus_a  = r_a[11:0];
            bus_b  = r_b[11:0];
            w_next = ST_S2;
         end
         ST_S2: begin
            flag   = 4'b0010;
            bus_a  = r_a[23:12];
            bus_b  = r_b[23:12];
            w_next = ST_S3;
         end
         ST_S3: begin
            flag   = 4'b0100;
            bus_a  = r_a[35:24];
            bus_b  = r_b[35:24];
            w_next = ST_S4;
         end
         ST_S4: begin
            flag   = 4'b1000;
            bus_a  = r_a[47:36];
            bus_b  = r_b[47:36];
            w_next = ST_LOAD;
         end
         ST_LOAD: begin
            load_ready = 1'b1;
            if (r_cnt == 3'd0) begin
               w_next = ST_CAPT;
            end
         end
         ST_CAPT: begin
            w_next = ST_DONE;
         end
         ST_DONE: begin
            busy   = 1'b0;
            done   = 1'b1;
            w_next = ST_IDLE;
         end
         default: begin
            busy   = 1'b0;
            w_next = ST_IDLE;
         end
      endcase
   end

   assign ci48 = busy & r_ci;
   assign sum  = r_sum;
   assign co   = r_co;

endmodule

// File: tb/tb_sa48_sequencer.sv
// Bench for sa48_sequencer: a cycle-offset reference model plus a slice-collecting
// datapath stub, driven by directed scenarios and then random traffic.
module tb_sa48_sequencer;
   localparam int LW = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [47:0] a_in = '0;
   logic [47:0] b_in = '0;
   logic        ci_in = 1'b0;
   logic [11:0] bus_a;
   logic [11:0] bus_b;
   logic [3:0]  flag;
   logic        load_ready;
   logic        ci48;
   logic [47:0] dp_sum = '0;
   logic        dp_co = 1'b0;
   logic        busy;
   logic        done;
   logic [47:0] sum;
   logic        co;

   always #5 clk = ~clk;

   sa48_sequencer #(.LOAD_WAIT(LW)) dut (
      .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .ci_in(ci_in),
      .bus_a(bus_a), .bus_b(bus_b), .flag(flag), .load_ready(load_ready), .ci48(ci48),
      .dp_sum(dp_sum), .dp_co(dp_co), .busy(busy), .done(done), .sum(sum), .co(co)
   );

   // Datapath stub: gathers slices as they are strobed, adds on load_ready, and
   // scrambles the result with a per-operation mask so the sequencer cannot fake it.
   logic [47:0] dpa = '0;
   logic [47:0] dpb = '0;
   logic [47:0] dp_mask = '0;
   logic        dp_mask_co = 1'b0;

   always @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (flag[k]) begin
            dpa[k*12 +: 12] <= bus_a;
            dpb[k*12 +: 12] <= bus_b;
         end
      end
      if (load_ready) begin
         {dp_co, dp_sum} <= ({1'b0, dpa} + {1'b0, dpb} + 49'(ci48)) ^ {dp_mask_co, dp_mask};
      end
   end

   int n_checks = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   // Reference model: ph is the number of cycles since the start was accepted (0 = idle).
   int          cyc = 0;
   int          ph = 0;
   logic [47:0] m_a = '0;
   logic [47:0] m_b = '0;
   logic        m_ci = 1'b0;
   logic [48:0] m_res = '0;
   logic [47:0] m_sum = '0;
   logic        m_co = 1'b0;
   bit          use_mask = 1'b0;
   int          done_cyc[$];

   task automatic check_outputs();
      logic [3:0]  e_flag;
      logic [11:0] e_ba;
      logic [11:0] e_bb;
      logic        e_lr;
      logic        e_busy;
      logic        e_done;
      e_flag = 4'b0000;
      e_ba   = 12'd0;
      e_bb   = 12'd0;
      if (ph >= 1 && ph <= 4) begin
         e_flag = 4'(1 << (ph - 1));
         e_ba   = m_a[(ph-1)*12 +: 12];
         e_bb   = m_b[(ph-1)*12 +: 12];
      end
      e_lr   = (ph >= 5 && ph <= 4 + LW);
      e_busy = (ph >= 1 && ph <= 5 + LW);
      e_done = (ph == 6 + LW);
      chk("flag", 64'(flag), 64'(e_flag));
      chk("bus_a", 64'(bus_a), 64'(e_ba));
      chk("bus_b", 64'(bus_b), 64'(e_bb));
      chk("load_ready", 64'(load_ready), 64'(e_lr));
      chk("busy", 64'(busy), 64'(e_busy));
      chk("done", 64'(done), 64'(e_done));
      chk("ci48", 64'(ci48), 64'(e_busy & m_ci));
      chk("sum", 64'(sum), 64'(m_sum));
      chk("co", 64'(co), 64'(m_co));
      chk("mutex", 64'(int'(flag != 4'd0) + int'(load_ready) + int'(done) <= 1), 64'd1);
      if (done === 1'b1) done_cyc.push_back(cyc);
   endtask

   task automatic step(input logic s, input logic r, input logic [47:0] a, input logic [47:0] b,
                       input logic c);
      @(negedge clk);
      if (cyc > 0) check_outputs();
      start = s;
      rst   = r;
      a_in  = a;
      b_in  = b;
      ci_in = c;
      if (r) begin
         ph    = 0;
         m_sum = '0;
         m_co  = 1'b0;
      end else if (ph == 0) begin
         if (s) begin
            ph         = 1;
            m_a        = a;
            m_b        = b;
            m_ci       = c;
            dp_mask    = use_mask ? 48'({$urandom(), $urandom()}) : 48'd0;
            dp_mask_co = use_mask ? 1'($urandom()) : 1'b0;
            m_res      = ({1'b0, a} + {1'b0, b} + 49'(c)) ^ {dp_mask_co, dp_mask};
         end
      end else begin
         if (ph == 5 + LW) {m_co, m_sum} = m_res;
         ph = (ph == 6 + LW) ? 0 : ph + 1;
      end
      cyc++;
   endtask

   function automatic logic [47:0] rnd48();
      return 48'({$urandom(), $urandom()});
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, rnd48(), rnd48(), 1'($urandom()));
   endtask

   initial begin
      int nd;
      step(1'b0, 1'b1, '0, '0, 1'b0);
      step(1'b0, 1'b1, '0, '0, 1'b0);
      idle(2);

      // basic add; operands scrambled after acceptance
      step(1'b1, 1'b0, 48'h000000000001, 48'h000000000001, 1'b0);
      idle(8 + LW);
      chk("basic_sum", 64'(sum), 64'h2);
      chk("basic_co", 64'(co), 64'h0);

      // full carry ripple
      step(1'b1, 1'b0, 48'hFFFFFFFFFFFF, 48'h000000000000, 1'b1);
      idle(8 + LW);
      chk("carry_sum", 64'(sum), 64'h0);
      chk("carry_co", 64'(co), 64'h1);

      // slice mapping, plus a start pulse during S3 that must be ignored
      nd = done_cyc.size();
      step(1'b1, 1'b0, 48'hABC123456DEF, 48'h0123456789AB, 1'b0);
      idle(2);
      step(1'b1, 1'b0, rnd48(), rnd48(), 1'b1);
      idle(8 + LW);
      chk("busy_start_dones", 64'(done_cyc.size() - nd), 64'd1);
      chk("slice_sum", 64'(sum), 64'(48'hABC123456DEF + 48'h0123456789AB));

      // reset during S2 aborts without done
      nd = done_cyc.size();
      step(1'b1, 1'b0, rnd48(), rnd48(), 1'b1);
      idle(1);
      step(1'b0, 1'b1, rnd48(), rnd48(), 1'b0);
      idle(10 + LW);
      chk("abort_dones", 64'(done_cyc.size() - nd), 64'd0);

      // start held high: done every 7+LW cycles
      done_cyc.delete();
      for (int i = 0; i < 45; i++) step(1'b1, 1'b0, rnd48(), rnd48(), 1'($urandom()));
      idle(10 + LW);
      chk("b2b_count", 64'(done_cyc.size() >= 3), 64'd1);
      for (int i = 1; i < done_cyc.size(); i++)
         chk("b2b_gap", 64'(done_cyc[i] - done_cyc[i-1]), 64'(7 + LW));

      // random traffic with scrambled datapath results and occasional resets
      use_mask = 1'b1;
      for (int i = 0; i < 1500; i++)
         step($urandom_range(0, 2) == 0, $urandom_range(0, 63) == 0, rnd48(), rnd48(),
              1'($urandom()));
      idle(12 + LW);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
